// File: rtl/port_skid_bank.sv
// port_skid_bank: multi-lane registered valid/ready bridge.
// Each lane has a 2-entry skid buffer, reset default and optional inversion.
module port_skid_bank #(
  parameter int                  WIDTH       = 8,
  parameter int                  CHANNELS    = 2,
  parameter logic [WIDTH-1:0]    RESET_VALUE = '0,
  parameter logic [CHANNELS-1:0] INVERT      = '0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       out_valid,
  input  logic [CHANNELS-1:0]       out_ready,
  output logic [CHANNELS*WIDTH-1:0] out_data,
  output logic [2*CHANNELS-1:0]     occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
    state_t           state_q;
    state_t           state_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] skid_q;
    logic [WIDTH-1:0] skid_d;
    logic [WIDTH-1:0] cap;
    logic             push;
    logic             pop;

    assign cap  = in_data[c*WIDTH +: WIDTH] ^ {WIDTH{INVERT[c]}};
    assign push = in_valid[c] & (state_q != FULL);
    assign pop  = out_ready[c] & (state_q != EMPTY);

    assign in_ready[c]             = (state_q != FULL);
    assign out_valid[c]            = (state_q != EMPTY);
    assign out_data[c*WIDTH +: WIDTH] = main_q;
    assign occupancy[2*c +: 2]     = state_q;

    // next-state and register updates for one lane
    always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
        EMPTY: begin
          if (push) begin
            state_d = ONE;
            main_d  = cap;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_d = cap;
          end else if (push) begin
            state_d = FULL;
            skid_d  = cap;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            state_d = ONE;
            main_d  = skid_q;
          end
        end
        default: state_d = EMPTY;
      endcase
    end

    // lane state, head and spill registers
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= EMPTY;
        main_q  <= RESET_VALUE;
        skid_q  <= RESET_VALUE;
      end else begin
        state_q <= state_d;
        main_q  <= main_d;
        skid_q  <= skid_d;
      end
    end
  end

endmodule

// File: tb/tb_port_skid_bank.sv
// tb_port_skid_bank: directed bench for port_skid_bank.
// Per-lane 2-deep FIFO model checked every cycle, plus literal checks.
module tb_port_skid_bank;

  localparam int         W   = 8;
  localparam int         CH  = 2;
  localparam logic [7:0] RV  = 8'hA5;
  localparam logic [1:0] INV = 2'b10;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [1:0]    in_valid = '0;
  logic [1:0]    in_ready;
  logic [15:0]   in_data = '0;
  logic [1:0]    out_valid;
  logic [1:0]    out_ready = '0;
  logic [15:0]   out_data;
  logic [3:0]    occupancy;

  int checks = 0;
  int errors = 0;

  port_skid_bank #(
    .WIDTH(W), .CHANNELS(CH), .RESET_VALUE(RV), .INVERT(INV)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // model: per-lane FIFO of depth 2 plus last popped value
  logic [7:0] mem [2][2];
  int         cnt [2];
  logic [7:0] last [2];
  bit         model_ok = 0;
  bit         m_push;
  bit         m_pop;
  logic [7:0] m_d;

  always @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 2; c++) begin
        cnt[c]  = 0;
        last[c] = RV;
      end
      model_ok = 1;
    end else if (model_ok) begin
      for (int c = 0; c < 2; c++) begin
        m_push = in_valid[c] && cnt[c] < 2;
        m_pop  = out_ready[c] && cnt[c] > 0;
        m_d    = in_data[c*8 +: 8] ^ {8{INV[c]}};
        if (m_pop) begin
          last[c]   = mem[c][0];
          mem[c][0] = mem[c][1];
          cnt[c]    = cnt[c] - 1;
        end
        if (m_push) begin
          mem[c][cnt[c]] = m_d;
          cnt[c]         = cnt[c] + 1;
        end
      end
    end
  end

  // compare DUT to model every cycle once reset has been seen
  always @(negedge clk) begin
    if (model_ok) begin
      for (int c = 0; c < 2; c++) begin
        chk($sformatf("m_ov%0d", c), 32'(out_valid[c]), 32'(cnt[c] != 0));
        chk($sformatf("m_ir%0d", c), 32'(in_ready[c]), 32'(cnt[c] < 2));
        chk($sformatf("m_occ%0d", c), 32'(occupancy[2*c +: 2]), 32'(cnt[c]));
        chk($sformatf("m_dat%0d", c), 32'(out_data[c*8 +: 8]),
            32'(cnt[c] != 0 ? mem[c][0] : last[c]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    in_valid  = '0;
    out_ready = 2'b11;
    step();
    step();
    step();
    out_ready = '0;
  endtask

  initial begin
    step();
    step();
    rst = 1'b0;
    chk("rst_data", 32'(out_data), 32'h0000A5A5);
    chk("rst_ov", 32'(out_valid), 32'h0);
    chk("rst_ir", 32'(in_ready), 32'h3);
    chk("rst_occ", 32'(occupancy), 32'h0);

    // single push on lane 0
    in_valid = 2'b01;
    in_data  = 16'h003C;
    step();
    in_valid = '0;
    chk("push_ov", 32'(out_valid), 32'h1);
    chk("push_dat", 32'(out_data), 32'hA53C);
    drain();

    // inversion on lane 1 only
    in_valid = 2'b11;
    in_data  = 16'h0F0F;
    step();
    in_valid = '0;
    chk("inv_dat", 32'(out_data), 32'hF00F);
    drain();

    // fill lane 0, third push ignored
    in_valid = 2'b01;
    in_data  = 16'h0011;
    step();
    in_data = 16'h0022;
    step();
    chk("full_occ", 32'(occupancy[1:0]), 32'h2);
    chk("full_ir", 32'(in_ready[0]), 32'h0);
    in_data = 16'h0033;
    step();
    in_valid = '0;
    chk("full_head", 32'(out_data[7:0]), 32'h11);
    out_ready = 2'b01;
    step();
    chk("pop1_dat", 32'(out_data[7:0]), 32'h22);
    chk("pop1_occ", 32'(occupancy[1:0]), 32'h1);
    step();
    chk("pop2_occ", 32'(occupancy[1:0]), 32'h0);
    chk("pop2_dat", 32'(out_data[7:0]), 32'h22);
    step();
    chk("no33_ov", 32'(out_valid[0]), 32'h0);
    out_ready = '0;

    // stream lane 0; random traffic on lane 1
    for (int i = 0; i < 100; i++) begin
      in_valid  = {1'($urandom), 1'b1};
      in_data   = {8'($urandom), 8'(i)};
      out_ready = {1'($urandom), 1'b1};
      step();
      chk("str_ov", 32'(out_valid[0]), 32'h1);
      chk("str_dat", 32'(out_data[7:0]), 32'(i));
    end
    drain();

    // full lane with push and pop together: pop only
    in_valid = 2'b01;
    in_data  = 16'h00AA;
    step();
    in_data = 16'h00BB;
    step();
    in_data   = 16'h00CC;
    out_ready = 2'b01;
    step();
    in_valid  = '0;
    out_ready = '0;
    chk("fp_occ", 32'(occupancy[1:0]), 32'h1);
    chk("fp_ir", 32'(in_ready[0]), 32'h1);
    chk("fp_dat", 32'(out_data[7:0]), 32'hBB);
    drain();

    // reset while lane 1 full
    in_valid = 2'b10;
    in_data  = 16'hD100;
    step();
    in_data = 16'hD200;
    step();
    chk("rf_occ", 32'(occupancy[3:2]), 32'h2);
    rst       = 1'b1;
    in_valid  = 2'b11;
    in_data   = 16'h7777;
    out_ready = 2'b11;
    step();
    rst      = 1'b0;
    in_valid = '0;
    chk("rr_occ", 32'(occupancy), 32'h0);
    chk("rr_ov", 32'(out_valid), 32'h0);
    chk("rr_dat", 32'(out_data), 32'h0000A5A5);
    chk("rr_ir", 32'(in_ready), 32'h3);
    step();
    step();
    chk("rr_gone", 32'(out_valid), 32'h0);
    out_ready = '0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/port_skid_bank.md
# port_skid_bank

Parametrised, multi-channel registered port bridge: CHANNELS independent valid/ready lanes of WIDTH bits, each with a 2-entry skid buffer, a reset/default output value and an optional per-channel bit inversion. It generalises single-bit, unregistered port passing with output defaults and inverted drive into a clocked, back-pressured, multi-lane block. It sits between unit boundaries where a full-throughput registered cut with no combinational ready path is required.

## Interface
- WIDTH, 8, data bits per channel (>=1)
- CHANNELS, 2, number of independent lanes (>=1)
- RESET_VALUE, 0, WIDTH-bit value on every out_data lane after reset until its first capture
- INVERT, 0, CHANNELS-bit mask; bit c set -> lane c data is bitwise inverted on capture

- clk  input  1  clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  CHANNELS  producer valid, bit c per lane
- in_ready  output  CHANNELS  lane c can accept this cycle
- in_data  input  CHANNELS*WIDTH  lane c at bits [c*WIDTH +: WIDTH]
- out_valid  output  CHANNELS  lane c holds data
- out_ready  input  CHANNELS  consumer ready, bit c per lane
- out_data  output  CHANNELS*WIDTH  lane c head entry, same packing as in_data
- occupancy  output  2*CHANNELS  lane c entry count (0..2) at bits [2c +: 2]

## Operation
- Lanes fully independent; no shared state or arbitration.
- Per lane: head register `main`, spill register `skid`, state EMPTY / ONE / FULL.
- Transfer in: in_valid[c] & in_ready[c]. Transfer out: out_valid[c] & out_ready[c].
- Captured value = in_data lane XOR {WIDTH{INVERT[c]}}; inversion is applied once, at capture.
- Transitions:
  - EMPTY: in -> ONE, main <= data; else stay.
  - ONE: in & out -> ONE, main <= data; in & !out -> FULL, skid <= data; !in & out -> EMPTY; else stay.
  - FULL: out -> ONE, main <= skid; else stay. in_ready = 0, so no capture.
- Outputs: out_valid[c] = (state != EMPTY); in_ready[c] = (state != FULL); out_data lane = main; occupancy = 0/1/2 for EMPTY/ONE/FULL.
- main is not cleared on pop: when EMPTY, out_data shows the last popped value, or RESET_VALUE if nothing has been captured since reset. Consumers must qualify with out_valid.
- Strict FIFO order per lane; no drops or duplicates.
- in_data, in_valid, out_ready while in_ready=0 or out_valid=0 are ignored; no error flag.

## Timing
- Reset (rst=1 at an edge): all lanes EMPTY; main and skid <= RESET_VALUE. Next cycle: out_valid=0, in_ready=all 1, occupancy=0, out_data = RESET_VALUE on every lane.
- Reset mid-operation discards both entries; nothing buffered is presented afterwards. Reset takes priority over simultaneous in/out transfers in the same cycle.
- Latency: data captured at edge N is on out_data with out_valid=1 from edge N to N+1, i.e. 1 cycle.
- Throughput: 1 transfer/cycle/lane sustained with out_ready held high.
- in_ready and out_valid are pure register outputs; no combinational path from out_ready or in_valid to any output.
- FULL with out_ready=1 and in_valid=1: pop only. in_ready is 0 that cycle, and in_ready=1 next cycle.
- ONE with simultaneous in and out: stays ONE, and the new data replaces main on the same edge.

## Test plan
- Reset with RESET_VALUE=8'hA5 -> out_data lanes = A5, out_valid=0, in_ready=all 1, occupancy=0. Push 8'h3C on lane 0 -> next cycle out_valid[0]=1, out_data lane0=3C.
- INVERT=2'b10, push 8'h0F on both lanes -> lane0 outputs 0F, lane1 outputs F0.
- Lane 0 out_ready=0, push 11 then 22 -> occupancy=2, in_ready[0]=0, third push 33 ignored. out_ready=1 -> outputs 11, 22 in order, and 33 never appears.
- Streaming 100 incrementing values with out_ready=1 -> one output per cycle, in order, 1-cycle latency. Random out_ready on lane 1 -> lane 0 stream unaffected.
- FULL lane with in_valid=1 and out_ready=1 in the same cycle -> pop only, occupancy 2->1, next cycle in_ready=1.
- Assert rst while lane 1 is FULL -> next cycle occupancy=0, out_valid=0, out_data=RESET_VALUE, and the buffered entries are never output.
